// File: rtl/addsub_seq_ctrl_if.sv
// Command/result handshake bundle for the add/sub sequencer.
// The master issues commands; the slave reports busy/done and results.
interface addsub_seq_ctrl_if;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       acc_clr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic [3:0] acc;

  modport master (
    output start, op, a, b, acc_clr,
    input  busy, done, result, cout, ovf, acc
  );

  modport slave (
    input  start, op, a, b, acc_clr,
    output busy, done, result, cout, ovf, acc
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Sequencer driving one shared 4-bit adder/subtractor.
// Runs ADD/SUB/ACC in one pass and unsigned MUL as 4-step shift-add.
module addsub_seq_ctrl #(
  parameter int W         = 4,
  parameter bit STICKY_OV = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  addsub_seq_ctrl_if.slave cmd,
  output logic [W-1:0] as_x,
  output logic [W-1:0] as_y,
  output logic         as_cin,
  output logic         as_sub,
  input  logic [W-1:0] as_s,
  input  logic         as_cout,
  input  logic         as_ov
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_ACC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic [W-1:0]   hi_q, lo_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] result_q;
  logic           cout_q, ovf_q;
  logic [W-1:0]   acc_q;
  logic           busy, done;
  logic           last_step;

  assign last_step  = (cnt_q == CW'(W - 1));
  assign cmd.busy   = busy;
  assign cmd.done   = done;
  assign cmd.result = result_q;
  assign cmd.cout   = cout_q;
  assign cmd.ovf    = ovf_q;
  assign cmd.acc    = acc_q;

  always_comb begin
    state_d = state_q;
    as_x    = '0;
    as_y    = '0;
    as_cin  = 1'b0;
    as_sub  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd.start)
          state_d = (cmd.op == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        as_x    = (op_q == OP_ACC) ? acc_q : a_q;
        as_y    = (op_q == OP_ACC) ? a_q : b_q;
        as_sub  = (op_q == OP_SUB);
        state_d = S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        as_x = hi_q;
        as_y = lo_q[0] ? a_q : '0;
        if (last_step)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          // clear precedes a same-cycle ACC, which then reads acc=0
          if (cmd.acc_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (cmd.start) begin
            a_q   <= cmd.a;
            b_q   <= cmd.b;
            op_q  <= cmd.op;
            hi_q  <= '0;
            lo_q  <= cmd.b;
            cnt_q <= '0;
          end
        end
        S_EXEC: begin
          result_q <= {{W{1'b0}}, as_s};
          cout_q   <= as_cout;
          if (op_q == OP_ACC) begin
            acc_q <= as_s;
            ovf_q <= STICKY_OV ? (ovf_q | as_ov) : as_ov;
          end else begin
            ovf_q <= as_ov;
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= {as_cout, as_s, lo_q[W-1:1]};
          cnt_q        <= cnt_q + 1'b1;
          if (last_step) begin
            result_q <= {as_cout, as_s, lo_q[W-1:1]};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Randomized bench for addsub_seq_ctrl with a behavioural adder
// and an arithmetic reference model of the command results.
module tb_addsub_seq_ctrl;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_ACC = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] as_x, as_y, as_s;
  logic       as_cin, as_sub, as_cout, as_ov;

  addsub_seq_ctrl_if cmd();

  addsub_seq_ctrl #(.W(4), .STICKY_OV(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd),
    .as_x    (as_x),
    .as_y    (as_y),
    .as_cin  (as_cin),
    .as_sub  (as_sub),
    .as_s    (as_s),
    .as_cout (as_cout),
    .as_ov   (as_ov)
  );

  always #5 clk = ~clk;

  logic [3:0] yy;
  logic [4:0] tt;
  always_comb begin
    yy      = as_sub ? ~as_y : as_y;
    tt      = {1'b0, as_x} + {1'b0, yy} + {4'b0, (as_sub | as_cin)};
    as_s    = tt[3:0];
    as_cout = tt[4];
    as_ov   = (as_x[3] == yy[3]) && (tt[3] != as_x[3]);
  end

  int n_chk  = 0;
  int n_pass = 0;

  int m_res, m_cout, m_ovf, m_acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int sgn(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int out_rng(input int v);
    return (v > 7 || v < -8) ? 1 : 0;
  endfunction

  task automatic model_cmd(input logic [1:0] o, input int x, input int y,
                           input bit clr);
    int s;
    if (clr) begin
      m_acc = 0;
      m_ovf = 0;
    end
    case (o)
      OP_ADD: begin
        s      = x + y;
        m_res  = s % 16;
        m_cout = s / 16;
        m_ovf  = out_rng(sgn(x) + sgn(y));
      end
      OP_SUB: begin
        m_res  = (x - y + 16) % 16;
        m_cout = (x >= y) ? 1 : 0;
        m_ovf  = out_rng(sgn(x) - sgn(y));
      end
      OP_MUL: begin
        m_res  = x * y;
        m_cout = 0;
        m_ovf  = 0;
      end
      default: begin
        s      = m_acc + x;
        m_ovf  = m_ovf | out_rng(sgn(m_acc) + sgn(x));
        m_res  = s % 16;
        m_cout = s / 16;
        m_acc  = m_res;
      end
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y, input bit clr, input bit inj);
    int n;
    bit seen;
    @(negedge clk);
    cmd.start   = 1'b1;
    cmd.op      = o;
    cmd.a       = x;
    cmd.b       = y;
    cmd.acc_clr = clr;
    model_cmd(o, int'(x), int'(y), clr);
    @(negedge clk);
    chk("busy", cmd.busy, 1);
    if (inj) begin
      cmd.start   = 1'b1;
      cmd.op      = 2'($urandom);
      cmd.a       = 4'($urandom);
      cmd.b       = 4'($urandom);
      cmd.acc_clr = 1'b1;
    end else begin
      cmd.start   = 1'b0;
      cmd.acc_clr = 1'b0;
    end
    n    = 1;
    seen = 0;
    while (!seen && n < 20) begin
      if (cmd.done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("latency", n, (o == OP_MUL) ? 5 : 2);
    chk("result", cmd.result, m_res);
    chk("cout", cmd.cout, m_cout);
    chk("ovf", cmd.ovf, m_ovf);
    chk("acc", cmd.acc, m_acc);
    cmd.start   = 1'b0;
    cmd.acc_clr = 1'b0;
    @(negedge clk);
    chk("idle", {cmd.busy, cmd.done}, 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    cmd.acc_clr = 1'b1;
    @(negedge clk);
    cmd.acc_clr = 1'b0;
    m_acc = 0;
    m_ovf = 0;
    chk("clr_acc", cmd.acc, 0);
    chk("clr_ovf", cmd.ovf, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {cmd.busy, cmd.done, cmd.result, cmd.cout, cmd.ovf, cmd.acc},
        0);
  endtask

  initial begin
    reset_n     = 1'b0;
    cmd.start   = 1'b0;
    cmd.op      = OP_ADD;
    cmd.a       = '0;
    cmd.b       = '0;
    cmd.acc_clr = 1'b0;
    m_res = 0; m_cout = 0; m_ovf = 0; m_acc = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    do_cmd(OP_ADD, 4'd7, 4'd5, 0, 0);
    do_cmd(OP_SUB, 4'd3, 4'd5, 0, 0);
    do_cmd(OP_SUB, 4'd5, 4'd3, 0, 0);
    do_cmd(OP_MUL, 4'd15, 4'd15, 0, 0);
    do_cmd(OP_MUL, 4'd0, 4'd9, 0, 0);
    do_cmd(OP_MUL, 4'd6, 4'd1, 0, 0);
    do_clr();
    repeat (3) do_cmd(OP_ACC, 4'd4, 4'd0, 0, 0);
    do_clr();
    do_cmd(OP_MUL, 4'd9, 4'd7, 0, 1);
    do_cmd(OP_ADD, 4'd2, 4'd3, 0, 1);
    do_cmd(OP_ACC, 4'd9, 4'd0, 1, 0);

    for (int i = 0; i < 40; i++)
      do_cmd(2'($urandom), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));

    @(negedge clk);
    cmd.start = 1'b1;
    cmd.op    = OP_MUL;
    cmd.a     = 4'd15;
    cmd.b     = 4'd15;
    @(negedge clk);
    cmd.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_mul_reset");
    reset_n = 1'b1;
    m_res = 0; m_cout = 0; m_ovf = 0; m_acc = 0;
    do_cmd(OP_ADD, 4'd1, 4'd1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
